// File: rtl/layer2_mac_array_pkg.sv
// Shared constants and FSM encoding for the Layer-2 multiply-accumulate engine.
package layer2_mac_array_pkg;

    localparam int RELU_NODES           = 20;
    localparam int RELU_INDEX_WIDTH     = 5;
    localparam int LAYER_2_IN_BIT_WIDTH = 8;
    localparam int OUT_NODES            = 10;
    localparam int WEIGHT_W             = 8;
    localparam int ACC_W                = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEQ_HI = 3'd1,
        DEQ_LO = 3'd2,
        FETCH  = 3'd3,
        MAC    = 3'd4,
        DONE   = 3'd5
    } mac_state_t;

endpackage

// File: rtl/layer2_mac_array_sat_mac_lane.sv
// One accumulator lane: acc <= sat(acc + unsigned value * signed weight),
// with a synchronous clear that takes priority over the accumulate.
module sat_mac_lane #(
    parameter int IN_W     = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [IN_W-1:0]     value,
    input  logic [WEIGHT_W-1:0] weight,
    output logic [ACC_W-1:0]    acc
);

    localparam int PROD_W = IN_W + 1 + WEIGHT_W;
    // The sum is one bit wider than the wider operand so it can never wrap,
    // even when the accumulator is narrower than a single product.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam int PAD_W  = SUM_W - ACC_W + 1;

    logic signed [PROD_W-1:0] value_ext;
    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  max_val;
    logic signed [SUM_W-1:0]  min_val;
    logic [ACC_W-1:0]         next_acc;

    always_comb begin
        value_ext  = PROD_W'($signed({1'b0, value}));
        weight_ext = PROD_W'($signed(weight));
        product    = value_ext * weight_ext;
        max_val    = $signed({{PAD_W{1'b0}}, {(ACC_W-1){1'b1}}});
        min_val    = $signed({{PAD_W{1'b1}}, {(ACC_W-1){1'b0}}});
        sum        = SUM_W'($signed(acc)) + SUM_W'(product);
        if (sum > max_val) begin
            next_acc = max_val[ACC_W-1:0];
        end else if (sum < min_val) begin
            next_acc = min_val[ACC_W-1:0];
        end else begin
            next_acc = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= next_acc;
        end
    end

endmodule

// File: rtl/layer2_mac_array.sv
// Layer-2 MAC engine: drains the ReLU node queue, fetches each node's weight
// row and accumulates value * weight into one saturating lane per output node.
module layer2_mac_array #(
    parameter int RELU_NODES       = layer2_mac_array_pkg::RELU_NODES,
    parameter int RELU_INDEX_WIDTH = layer2_mac_array_pkg::RELU_INDEX_WIDTH,
    parameter int IN_W             = layer2_mac_array_pkg::LAYER_2_IN_BIT_WIDTH,
    parameter int OUT_NODES        = layer2_mac_array_pkg::OUT_NODES,
    parameter int WEIGHT_W         = layer2_mac_array_pkg::WEIGHT_W,
    parameter int ACC_W            = layer2_mac_array_pkg::ACC_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          queueEmpty,
    input  logic [RELU_INDEX_WIDTH-1:0]   indexIn,
    input  logic [IN_W-1:0]               nodeValueIn,
    output logic                          dequeue,
    output logic [RELU_INDEX_WIDTH-1:0]   weightIndex,
    input  logic [OUT_NODES*WEIGHT_W-1:0] weightRow,
    output logic [OUT_NODES*ACC_W-1:0]    accOut,
    output logic                          busy,
    output logic                          done
);

    import layer2_mac_array_pkg::*;

    if (RELU_NODES > (2 ** RELU_INDEX_WIDTH) - 1) begin : g_index_width_check
        $error("RELU_INDEX_WIDTH is too narrow to hold RELU_NODES");
    end

    mac_state_t      state;
    logic [IN_W-1:0] node_value;
    logic            clear_acc;
    logic            mac_en;

    assign clear_acc = (state == IDLE) && start;
    assign mac_en    = (state == MAC);

    // All outputs are registered so dequeue is a clean one-cycle pulse and
    // done lands one cycle after the DONE state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dequeue     <= 1'b0;
            weightIndex <= '0;
            node_value  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (queueEmpty) begin
                            state <= DONE;
                        end else begin
                            state   <= DEQ_HI;
                            dequeue <= 1'b1;
                        end
                    end
                end
                DEQ_HI: begin
                    dequeue <= 1'b0;
                    state   <= DEQ_LO;
                end
                DEQ_LO: begin
                    node_value  <= nodeValueIn;
                    weightIndex <= indexIn;
                    state       <= FETCH;
                end
                FETCH: begin
                    state <= MAC;
                end
                MAC: begin
                    if (queueEmpty) begin
                        state <= DONE;
                    end else begin
                        state   <= DEQ_HI;
                        dequeue <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    dequeue <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Node 0 sits in the MSBs of both the weight row and the accumulator bus.
    for (genvar k = 0; k < OUT_NODES; k++) begin : g_lane
        sat_mac_lane #(
            .IN_W     (IN_W),
            .WEIGHT_W (WEIGHT_W),
            .ACC_W    (ACC_W)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clear  (clear_acc),
            .enable (mac_en),
            .value  (node_value),
            .weight (weightRow[(OUT_NODES-1-k)*WEIGHT_W +: WEIGHT_W]),
            .acc    (accOut[(OUT_NODES-1-k)*ACC_W +: ACC_W])
        );
    end

endmodule

// File: doc/layer2_mac_array.md
# layer2_mac_array

Layer-2 multiply-accumulate engine that drains the ReLU node queue one entry per dequeue, fetches the matching weight row from Layer-2 weight storage and accumulates value × weight into one signed accumulator per output node. It sits directly downstream of the ReLU node queue and drives that queue's `dequeue` strobe. It also addresses the Layer-2 weight storage. Its accumulator bus feeds the output/argmax stage.

## Interface
- `RELU_NODES`, default 20: ReLU nodes per inference, equal to the queue depth.
- `RELU_INDEX_WIDTH`, default 5: width of the queue index. Must hold the value `RELU_NODES`.
- `IN_W`, default 8: width of a ReLU node value, unsigned.
- `OUT_NODES`, default 10: number of Layer-2 output nodes.
- `WEIGHT_W`, default 8: width of a Layer-2 weight, signed two's complement.
- `ACC_W`, default 24: width of each accumulator, signed.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous, active-high.
- `start` input 1: begin an inference pass. Sampled only in IDLE.
- `queueEmpty` input 1: queue empty flag, from the queue.
- `indexIn` input `RELU_INDEX_WIDTH`: index of the dequeued node, from the queue.
- `nodeValueIn` input `IN_W`: value of the dequeued node, from the queue.
- `dequeue` output 1: dequeue strobe to the queue.
- `weightIndex` output `RELU_INDEX_WIDTH`: row address to weight storage.
- `weightRow` input `OUT_NODES*WEIGHT_W`: weight row, valid 1 cycle after `weightIndex`. Output node 0 occupies the MSBs.
- `accOut` output `OUT_NODES*ACC_W`: accumulators. Node 0 occupies the MSBs.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the pass completes.

## Operation
- Reset values: FSM=IDLE; `dequeue`=0, `weightIndex`=0, `accOut`=0, `busy`=0, `done`=0. Captured value and index registers are also 0.
- **IDLE**
  - `start`=1: clear all accumulators. If `queueEmpty`=1, go to DONE; otherwise go to DEQ_HI.
  - Otherwise stay in IDLE. `accOut` holds the previous result.
- **DEQ_HI**: `dequeue`=1, then go to DEQ_LO. This is the queue's capture edge.
- **DEQ_LO**: `dequeue`=0, which advances the queue pointer.
  - Register `nodeValueIn` and `indexIn`.
  - Register `weightIndex` <= `indexIn`.
  - Go to FETCH.
- **FETCH**: wait for the weight row, then go to MAC.
- **MAC**: for every k, `acc[k]` <= sat(`acc[k]` + value × `w[k]`), then test `queueEmpty`:
  - `queueEmpty`=1: go to DONE.
  - Otherwise: go to DEQ_HI.
- **DONE**: `done`=1 for one cycle, then go to IDLE.
- Arithmetic:
  - Value is zero-extended to `IN_W+1` bits.
  - Product is signed, `IN_W+1+WEIGHT_W` bits, sign-extended to `ACC_W+1` bits before the add.
  - The sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Once saturated, a lane can move back toward zero on later terms.
- `start` is ignored while `busy`=1.
- Reset mid-pass: immediate abort to the reset values. `dequeue` drops asynchronously. The queue is reset by the same `reset`.

## Timing
- 4 cycles per node: DEQ_HI, DEQ_LO, FETCH, MAC.
- Full pass of N nodes: `done` rises 4N+1 cycles after the `start` sample edge.
- Empty queue at `start`: `done` rises 1 cycle after the `start` edge, with all accumulators at 0.
- `dequeue` is a registered, glitch-free pulse, exactly 1 cycle high and at least 1 cycle low between pulses.
- `queueEmpty` is sampled only in MAC, two cycles after the dequeue falling edge, so the queue's flag has settled.
- `accOut` updates only on the MAC edge, and is stable from DONE until the next `start`.
- `weightIndex` changes only on the DEQ_LO edge.

## Structure
- A shared package (the global defines file) holds `RELU_NODES`, `RELU_INDEX_WIDTH`, `LAYER_2_IN_BIT_WIDTH` (= `IN_W`), `OUT_NODES`, `WEIGHT_W`, `ACC_W`, and the FSM state encodings.
- The natural sub-module is `sat_mac_lane`: one signed multiply-add with saturation and synchronous clear. It is instantiated `OUT_NODES` times by a generate loop.
- The top level holds the FSM, the capture registers and the bus pack/unpack.

## Test plan
- **Reset mid-pass:** assert reset during the 3rd node's FETCH. Expect all outputs 0 with `dequeue`=0 immediately, then IDLE. A new `start` gives a correct full result.
- **Empty queue:** `start` with `queueEmpty`=1. Expect `done` 1 cycle later, `accOut` all 0, and no `dequeue` pulse.
- **Single-node queue:** value 5 at index 0, weights w[k]=k-3. Expect `acc[k]`=5(k-3) (e.g. `acc[0]`=-15, `acc[9]`=30), `done` at cycle 5, exactly one `dequeue` pulse.
- **Full 20-node pass:** values i+1, all weights +1. Expect every `acc`=210, 20 `dequeue` pulses, `done` at cycle 81, and `weightIndex` sequence 0..19.
- **Saturation:** `ACC_W`=12, values 255, weights +127 and -128 in lane 0/1, over 20 nodes. Expect lane0 = 2047 and lane1 = -2048, held at the rails.
- **`start` while busy:** pulse `start` mid-pass. Expect no restart; the pass result is identical to the one without the extra `start`.
